cfg_afu_reset_seq: RTL
======================

Name: cfg_afu_reset_seq

Overview:
- Times function-level and AFU-level resets for config function 1.
- Sits directly downstream of the read-only config tie-off block. Consumes its `f1_ro_ofunc_reset_duration` and `f1_ro_octrl00_reset_duration` values.
- Accepts single-cycle reset requests decoded by cfg_func1 from writes to the OFUNC function-reset bit and the OCTRL00 reset-AFU bit.
- Drives the AFU reset, the reset-in-progress status bits read back by config space, and done pulses.

Parameters:
- TICK_CYCLES, 16, clock cycles per duration unit; legal range 1..1024.
- MIN_UNITS, 1, minimum duration units applied when a duration input is 0; legal range 1..255.

Ports:
- clock  in  1  block clock.
- reset_n  in  1  asynchronous active-low reset.
- ofunc_reset_duration  in  8  function reset duration in units, from `f1_ro_ofunc_reset_duration`.
- octrl_reset_duration  in  8  AFU reset duration in units, from `f1_ro_octrl00_reset_duration`.
- func_reset_req  in  1  one-cycle pulse; config write set the OFUNC function-reset bit.
- afu_reset_req  in  1  one-cycle pulse; config write set the OCTRL00 reset-AFU bit.
- afu_reset  out  1  active-high reset to the AFU.
- func_reset_in_progress  out  1  OFUNC status readback.
- afu_reset_in_progress  out  1  OCTRL00 status readback.
- func_reset_done  out  1  one-cycle completion pulse, function reset.
- afu_reset_done  out  1  one-cycle completion pulse, AFU reset.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, tick and unit counters=0. All outputs are 0.
- Interface decision: one clock; reset is asynchronous and active-low.
- FSM states: IDLE, FUNC_RST, AFU_RST.
- Effective units U = duration input if nonzero, else MIN_UNITS. The duration input is sampled only on the cycle the request is accepted; later changes are ignored.
- Reset hold time: afu_reset is high for exactly U*TICK_CYCLES cycles, starting the cycle after acceptance (cycle N+1 for a request in cycle N).
- Counters:
  - Tick counter counts 0..TICK_CYCLES-1 and wraps.
  - Unit counter loads U-1 and decrements on each tick wrap.
  - The state exits when the unit counter is 0 and the tick counter is TICK_CYCLES-1.
- IDLE:
  - func_reset_req -> FUNC_RST, load ofunc U.
  - Else afu_reset_req -> AFU_RST, load octrl U.
  - Simultaneous requests: the function reset wins and the AFU request is dropped, because the function reset covers the AFU.
- FUNC_RST:
  - afu_reset=1, func_reset_in_progress=1, afu_reset_in_progress=0.
  - All further requests are ignored.
  - On expiry: go to IDLE and pulse func_reset_done in the first cycle afu_reset is 0.
- AFU_RST:
  - afu_reset=1, afu_reset_in_progress=1.
  - afu_reset_req is ignored; no restart and no extension.
  - func_reset_req preempts: go to FUNC_RST next cycle, reload counters with ofunc U, and keep afu_reset high with no gap.
  - A preempted AFU reset produces no afu_reset_done.
  - On normal expiry: go to IDLE and pulse afu_reset_done.
- Done pulses: one cycle each, never both in the same cycle.
- Back-to-back requests: a request arriving in the same cycle as a done pulse (state is already IDLE) is accepted normally, so afu_reset drops for that one cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Width rule: the unit counter is 8 bits and the tick counter is clog2(TICK_CYCLES) bits, minimum 1.
- Maximum hold is 255*TICK_CYCLES cycles with no overflow.
- Reset asserted mid-operation: everything returns to IDLE immediately, afu_reset=0, no done pulse.

Test Plan:
- TICK_CYCLES=16, ofunc=0x10, func_reset_req at cycle 10 -> afu_reset and func_reset_in_progress high for cycles 11..266 (256 cycles). func_reset_done high at cycle 267 only.
- octrl=0x00, MIN_UNITS=1, afu_reset_req -> afu_reset high for exactly 16 cycles, then one afu_reset_done pulse. func_reset_in_progress stays 0.
- octrl=0x10, afu_reset_req at cycle 0, func_reset_req at cycle 50, ofunc=0x02 -> afu_reset continuous from cycle 1 through cycle 82. No afu_reset_done; func_reset_done at cycle 83.
- func_reset_req and afu_reset_req in the same cycle, ofunc=0x01 -> only FUNC_RST runs (16 cycles). afu_reset_in_progress never asserts; only func_reset_done pulses.
- afu_reset_req repeated every 5 cycles during AFU_RST with octrl=0x03 -> hold stays exactly 48 cycles. Exactly one afu_reset_done. The request landing on the done cycle starts a new reset the next cycle.
- reset_n pulsed low mid-FUNC_RST -> all outputs 0 asynchronously, no done pulse. A fresh request after release times correctly from zero.

Source files
------------

// File: rtl/cfg_afu_reset_seq.sv
// rtl/cfg_afu_reset_seq.sv - function-level / AFU-level reset sequencer for config function 1
//
// Times the AFU reset requested through config space. A request latches a
// duration (in units of TICK_CYCLES clocks) and holds afu_reset high for
// exactly units*TICK_CYCLES cycles, then pulses the matching done output.
// A function reset preempts a running AFU reset without releasing afu_reset.
//
// Ports:
//   clock                  block clock
//   reset_n                asynchronous active-low reset
//   ofunc_reset_duration   function reset duration in units (0 -> MIN_UNITS)
//   octrl_reset_duration   AFU reset duration in units (0 -> MIN_UNITS)
//   func_reset_req         one-cycle function reset request
//   afu_reset_req          one-cycle AFU reset request
//   afu_reset              active-high reset to the AFU
//   func_reset_in_progress OFUNC status readback
//   afu_reset_in_progress  OCTRL00 status readback
//   func_reset_done        one-cycle completion pulse, function reset
//   afu_reset_done         one-cycle completion pulse, AFU reset

module cfg_afu_reset_seq #(
    parameter int TICK_CYCLES = 16,
    parameter int MIN_UNITS   = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] ofunc_reset_duration,
    input  logic [7:0] octrl_reset_duration,
    input  logic       func_reset_req,
    input  logic       afu_reset_req,
    output logic       afu_reset,
    output logic       func_reset_in_progress,
    output logic       afu_reset_in_progress,
    output logic       func_reset_done,
    output logic       afu_reset_done
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [7:0]    MIN_LAST  = 8'(MIN_UNITS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FUNC_RST = 2'd1,
        AFU_RST  = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [7:0]    unit_cnt;
    logic          hold_expired;

    // Unit counter is loaded with U-1 so that it reaches 0 in the last unit.
    function automatic logic [7:0] first_unit(input logic [7:0] dur);
        if (dur == 8'd0) begin
            return MIN_LAST;
        end
        return dur - 8'd1;
    endfunction

    // True in the final cycle of the hold window.
    assign hold_expired = (unit_cnt == 8'd0) && (tick_cnt == TICK_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= IDLE;
            tick_cnt               <= '0;
            unit_cnt               <= 8'd0;
            afu_reset              <= 1'b0;
            func_reset_in_progress <= 1'b0;
            afu_reset_in_progress  <= 1'b0;
            func_reset_done        <= 1'b0;
            afu_reset_done         <= 1'b0;
        end else begin
            func_reset_done <= 1'b0;
            afu_reset_done  <= 1'b0;

            unique case (state)
                IDLE: begin
                    // Function reset covers the AFU, so it wins a tie and the
                    // AFU request is simply dropped.
                    if (func_reset_req) begin
                        state                  <= FUNC_RST;
                        tick_cnt               <= '0;
                        unit_cnt               <= first_unit(ofunc_reset_duration);
                        afu_reset              <= 1'b1;
                        func_reset_in_progress <= 1'b1;
                        afu_reset_in_progress  <= 1'b0;
                    end else if (afu_reset_req) begin
                        state                  <= AFU_RST;
                        tick_cnt               <= '0;
                        unit_cnt               <= first_unit(octrl_reset_duration);
                        afu_reset              <= 1'b1;
                        func_reset_in_progress <= 1'b0;
                        afu_reset_in_progress  <= 1'b1;
                    end
                end

                FUNC_RST: begin
                    if (hold_expired) begin
                        state                  <= IDLE;
                        tick_cnt               <= '0;
                        unit_cnt               <= 8'd0;
                        afu_reset              <= 1'b0;
                        func_reset_in_progress <= 1'b0;
                        func_reset_done        <= 1'b1;
                    end else if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        unit_cnt <= unit_cnt - 8'd1;
                    end else begin
                        tick_cnt <= tick_cnt + TICK_ONE;
                    end
                end

                AFU_RST: begin
                    // Preemption takes priority even in the expiry cycle so
                    // afu_reset never drops between the two holds.
                    if (func_reset_req) begin
                        state                  <= FUNC_RST;
                        tick_cnt               <= '0;
                        unit_cnt               <= first_unit(ofunc_reset_duration);
                        func_reset_in_progress <= 1'b1;
                        afu_reset_in_progress  <= 1'b0;
                    end else if (hold_expired) begin
                        state                 <= IDLE;
                        tick_cnt              <= '0;
                        unit_cnt              <= 8'd0;
                        afu_reset             <= 1'b0;
                        afu_reset_in_progress <= 1'b0;
                        afu_reset_done        <= 1'b1;
                    end else if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        unit_cnt <= unit_cnt - 8'd1;
                    end else begin
                        tick_cnt <= tick_cnt + TICK_ONE;
                    end
                end

                default: begin
                    state                  <= IDLE;
                    tick_cnt               <= '0;
                    unit_cnt               <= 8'd0;
                    afu_reset              <= 1'b0;
                    func_reset_in_progress <= 1'b0;
                    afu_reset_in_progress  <= 1'b0;
                end
            endcase
        end
    end

endmodule
